// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the bus arbiter/router: FSM states, arbitration
// mode encodings and the destination-mask decoder.
package bus_arb_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_POP,
      S_CHECK,
      S_PUSH
   } state_e;

   localparam logic MODE_RR   = 1'b0;
   localparam logic MODE_FP   = 1'b1;
   localparam int   MAX_DRVRS = 32;

   // Broadcast wins over a numerically valid ID; with a single driver the
   // broadcast mask collapses to zero and the packet is dropped.
   function automatic logic [MAX_DRVRS-1:0] dest_mask(
      input logic [31:0] id,
      input logic [4:0]  src,
      input int          n_drvrs,
      input logic [31:0] bcast
   );
      logic [31:0] all_m;
      all_m = (n_drvrs >= MAX_DRVRS) ? '1 : ((32'd1 << n_drvrs) - 32'd1);
      if (id == bcast) begin
         return all_m & ~(32'd1 << src);
      end else if (id < 32'(n_drvrs)) begin
         return 32'd1 << id[4:0];
      end
      return '0;
   endfunction

endpackage

// File: rtl/bus_arb_core.sv
// Request-to-grant selection: a rotating search starting at rr_ptr for
// round-robin, or a search starting at index 0 for fixed priority.
module bus_arb_core
   import bus_arb_pkg::*;
#(
   parameter int drvrs = 4
) (
   input  logic [drvrs-1:0]         pndng_i,
   input  logic [$clog2(drvrs)-1:0] rr_ptr_i,
   input  logic                     mode_i,
   output logic [$clog2(drvrs)-1:0] grant_o,
   output logic                     valid_o
);

   localparam int IDX_W = $clog2(drvrs);

   logic found;
   int   idx;

   // NOTE: every variable assigned here gets a default first, otherwise
   // synthesis infers a latch for the paths that do not assign it.
   always_comb begin
      grant_o = '0;
      found   = 1'b0;
      idx     = 0;
      valid_o = |pndng_i;
      for (int k = 0; k < drvrs; k++) begin
         if (mode_i == MODE_FP) begin
            idx = k;
         end else begin
            idx = int'(rr_ptr_i) + k;
            if (idx >= drvrs) begin
               idx = idx - drvrs;
            end
         end
         if (!found && pndng_i[IDX_W'(idx)]) begin
            grant_o = IDX_W'(idx);
            found   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_arb_router.sv
// Shared-bus arbiter/router: pops one packet from a pending driver, decodes its
// destination ID and pushes it to one driver or broadcasts it to all others.
module bus_arb_router
   import bus_arb_pkg::*;
#(
   parameter int              drvrs     = 4,
   parameter int              pckg_sz   = 16,
   parameter int              id_w      = 8,
   parameter logic [id_w-1:0] broadcast = {id_w{1'b1}},
   // Ceiling of the dropped-packet counter; 16'hFFFF in normal use.
   parameter logic [15:0]     drop_sat  = 16'hFFFF
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [drvrs-1:0]                pndng,
   input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
   output logic [drvrs-1:0]                pop,
   input  logic [drvrs-1:0]                full,
   input  logic                            mode,
   output logic [drvrs-1:0]                push,
   output logic [drvrs-1:0][pckg_sz-1:0]   D_push,
   output logic [15:0]                     drop_cnt,
   output logic                            busy
);

   localparam int IDX_W = $clog2(drvrs);

   state_e             state_q;
   logic [IDX_W-1:0]   rr_ptr_q;
   logic [IDX_W-1:0]   rr_ptr_d;
   logic [IDX_W-1:0]   src_q;
   logic [IDX_W-1:0]   grant_d;
   logic               grant_vld;
   logic [pckg_sz-1:0] pkt_q;
   logic [drvrs-1:0]   mask_q;
   logic [drvrs-1:0]   mask_d;
   logic [drvrs-1:0]   pop_q;
   logic [drvrs-1:0]   push_q;
   logic [15:0]        drop_q;

   bus_arb_core #(
      .drvrs (drvrs)
   ) u_core (
      .pndng_i  (pndng),
      .rr_ptr_i (rr_ptr_q),
      .mode_i   (mode),
      .grant_o  (grant_d),
      .valid_o  (grant_vld)
   );

   // The mask is decoded straight from the head being latched in POP.
   always_comb begin
      rr_ptr_d = (grant_d == IDX_W'(drvrs - 1)) ? '0 : grant_d + IDX_W'(1);
      mask_d   = drvrs'(dest_mask(32'(D_pop[src_q][pckg_sz-1 -: id_w]),
                                  5'(src_q), drvrs, 32'(broadcast)));
   end

   // NOTE: state is updated with non-blocking assignments only, so every
   // branch below sees the register values from before this edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         rr_ptr_q <= '0;
         src_q    <= '0;
         pkt_q    <= '0;
         mask_q   <= '0;
         pop_q    <= '0;
         push_q   <= '0;
         drop_q   <= '0;
      end else begin
         pop_q  <= '0;
         push_q <= '0;
         unique case (state_q)
            S_IDLE: begin
               if (grant_vld) begin
                  pop_q   <= drvrs'(1) << grant_d;
                  src_q   <= grant_d;
                  state_q <= S_POP;
                  if (mode == MODE_RR) begin
                     rr_ptr_q <= rr_ptr_d;
                  end
               end
            end
            S_POP: begin
               pkt_q   <= D_pop[src_q];
               mask_q  <= mask_d;
               state_q <= S_CHECK;
            end
            S_CHECK: begin
               // A broadcast only leaves once every target is free at once.
               if (mask_q == '0) begin
                  if (drop_q != drop_sat) begin
                     drop_q <= drop_q + 16'd1;
                  end
                  state_q <= S_IDLE;
               end else if ((mask_q & full) == '0) begin
                  push_q  <= mask_q;
                  state_q <= S_PUSH;
               end
            end
            S_PUSH: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign pop      = pop_q;
   assign push     = push_q;
   assign D_push   = {drvrs{pkt_q}};
   assign drop_cnt = drop_q;
   assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_bus_arb_router.sv
// Self-checking bench for bus_arb_router: directed vector table, multi-cycle
// corner sequences and a randomized run against a transaction-level model.
module tb_bus_arb_router;

   logic             clk;
   logic             reset;
   logic [3:0]       pndng;
   logic [3:0][15:0] D_pop;
   logic [3:0]       pop;
   logic [3:0]       full;
   logic             mode;
   logic [3:0]       push;
   logic [3:0][15:0] D_push;
   logic [15:0]      drop_cnt;
   logic             busy;

   logic [3:0]       pndng2;
   logic [3:0][15:0] D_pop2;
   logic [3:0]       pop2;
   logic [3:0]       full2;
   logic             mode2;
   logic [3:0]       push2;
   logic [3:0][15:0] D_push2;
   logic [15:0]      drop2;
   logic             busy2;

   int n_cmp;
   int n_err;

   bus_arb_router #(
      .drvrs (4), .pckg_sz (16), .id_w (8)
   ) dut (
      .clk (clk), .reset (reset), .pndng (pndng), .D_pop (D_pop), .pop (pop),
      .full (full), .mode (mode), .push (push), .D_push (D_push),
      .drop_cnt (drop_cnt), .busy (busy)
   );

   // Small saturation ceiling so the clamp is reachable in a short run.
   bus_arb_router #(
      .drvrs (4), .pckg_sz (16), .id_w (8), .drop_sat (16'd20)
   ) dut_sat (
      .clk (clk), .reset (reset), .pndng (pndng2), .D_pop (D_pop2), .pop (pop2),
      .full (full2), .mode (mode2), .push (push2), .D_push (D_push2),
      .drop_cnt (drop2), .busy (busy2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int model_grant(input logic [3:0] p, input logic m, input int rr);
      int start;
      start = m ? 0 : rr;
      for (int k = 0; k < 4; k++) begin
         if (p[(start + k) % 4]) return (start + k) % 4;
      end
      return -1;
   endfunction

   function automatic logic [3:0] model_mask(input logic [15:0] pkt, input int src);
      int id;
      id = int'(pkt[15:8]);
      if (id == 255) return 4'hF & ~(4'b0001 << src);
      if (id < 4)    return 4'b0001 << id;
      return 4'b0000;
   endfunction

   function automatic logic [15:0] rand_pkt();
      int sel;
      logic [7:0] id;
      sel = int'($urandom_range(0, 9));
      if (sel < 6)      id = 8'($urandom_range(0, 3));
      else if (sel < 8) id = 8'hFF;
      else              id = 8'($urandom_range(4, 254));
      return {id, 8'($urandom_range(0, 255))};
   endfunction

   typedef struct {
      logic [3:0]  mask;
      logic [15:0] pkt;
   } exp_t;

   exp_t exp_q[$];
   int   rr_m;
   int   drop_m;
   int   consume;

   // ---------------- helpers ----------------
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      pndng = '0;
      full  = '0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_pop(input string name, output logic [3:0] p);
      p = '0;
      for (int i = 0; i < 20 && p == '0; i++) begin
         @(negedge clk);
         p = pop;
      end
      check({name, "_seen"}, 64'(p != '0), 64'd1);
   endtask

   task automatic wait_push(input string name, output logic [3:0] p);
      p = '0;
      for (int i = 0; i < 20 && p == '0; i++) begin
         @(negedge clk);
         p = push;
      end
      check({name, "_seen"}, 64'(p != '0), 64'd1);
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 30 && busy; i++) @(negedge clk);
      check({name, "_idle"}, 64'(busy), 64'd0);
   endtask

   typedef struct {
      logic [3:0]       pndng;
      logic             mode;
      logic [3:0][15:0] dpop;
      logic [3:0]       exp_pop;
      logic [3:0]       exp_push;
      logic [15:0]      exp_data;
      logic [15:0]      exp_drop;
   } vec_t;

   task automatic run_vec(input vec_t v, input int n);
      string tag;
      tag = $sformatf("vec%0d", n);
      @(negedge clk);
      pndng = v.pndng;
      mode  = v.mode;
      full  = '0;
      D_pop = v.dpop;
      @(negedge clk);
      check({tag, "_pop"}, 64'(pop), 64'(v.exp_pop));
      check({tag, "_busy"}, 64'(busy), 64'd1);
      @(negedge clk);
      pndng = '0;
      check({tag, "_nopush"}, 64'(push), 64'd0);
      @(negedge clk);
      check({tag, "_push"}, 64'(push), 64'(v.exp_push));
      check({tag, "_data"}, 64'(D_push), {4{v.exp_data}});
      check({tag, "_drop"}, 64'(drop_cnt), 64'(v.exp_drop));
      @(negedge clk);
      check({tag, "_end"}, 64'({push, pop, busy}), 64'd0);
   endtask

   task automatic step(input bit gen);
      int         g;
      int         nxt;
      logic [3:0] m;
      exp_t       e;
      @(negedge clk);
      nxt = -1;
      if (pop != '0) begin
         g = model_grant(pndng, mode, rr_m);
         check("rnd_pop", 64'(pop), 64'(4'b0001 << g));
         if (g >= 0) begin
            m = model_mask(D_pop[g], g);
            if (m == '0) drop_m++;
            else exp_q.push_back('{mask: m, pkt: D_pop[g]});
            if (mode == 1'b0) rr_m = (g + 1) % 4;
            nxt = g;
         end
      end
      if (push != '0) begin
         if (exp_q.size() == 0) begin
            check("rnd_push_spurious", 64'(push), 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("rnd_push_mask", 64'(push), 64'(e.mask));
            check("rnd_push_data", 64'(D_push), {4{e.pkt}});
            check("rnd_push_full", 64'(push & full), 64'd0);
         end
      end
      if (!busy) check("rnd_drop", 64'(drop_cnt), 64'(drop_m));
      if (consume >= 0) pndng[consume] = 1'b0;
      consume = nxt;
      if (gen) begin
         for (int i = 0; i < 4; i++) begin
            if (!pndng[i] && $urandom_range(0, 2) == 0) begin
               pndng[i] = 1'b1;
               D_pop[i] = rand_pkt();
            end
            full[i] = ($urandom_range(0, 3) == 0);
         end
         if ($urandom_range(0, 15) == 0) mode = ~mode;
      end else begin
         full = '0;
      end
   endtask

   // ---------------- test sequence ----------------
   vec_t       vecs [10];
   logic [3:0] p;
   logic [3:0] seen;
   int         pops;

   initial begin
      n_cmp   = 0;
      n_err   = 0;
      reset   = 1'b1;
      pndng   = '0;
      D_pop   = '0;
      full    = '0;
      mode    = 1'b0;
      pndng2  = '0;
      D_pop2  = '0;
      full2   = '0;
      mode2   = 1'b0;
      consume = -1;

      vecs[0] = '{4'b0010, 1'b0, {16'h0D0D, 16'h0C0C, 16'h02AB, 16'h0A0A}, 4'b0010, 4'b0100, 16'h02AB, 16'd0};
      vecs[1] = '{4'b1000, 1'b0, {16'hFF55, 16'h0C0C, 16'h0B0B, 16'h0A0A}, 4'b1000, 4'b0111, 16'hFF55, 16'd0};
      vecs[2] = '{4'b1111, 1'b0, {16'h0D0D, 16'h0C0C, 16'h0B0B, 16'h0311}, 4'b0001, 4'b1000, 16'h0311, 16'd0};
      vecs[3] = '{4'b1111, 1'b0, {16'h0D0D, 16'h0C0C, 16'h0022, 16'h0A0A}, 4'b0010, 4'b0001, 16'h0022, 16'd0};
      vecs[4] = '{4'b1001, 1'b0, {16'h0133, 16'h0C0C, 16'h0B0B, 16'h0A0A}, 4'b1000, 4'b0010, 16'h0133, 16'd0};
      vecs[5] = '{4'b0001, 1'b0, {16'h0D0D, 16'h0C0C, 16'h0B0B, 16'hFF01}, 4'b0001, 4'b1110, 16'hFF01, 16'd0};
      vecs[6] = '{4'b1111, 1'b1, {16'h0D0D, 16'h0C0C, 16'h0B0B, 16'h0000}, 4'b0001, 4'b0001, 16'h0000, 16'd0};
      vecs[7] = '{4'b1100, 1'b1, {16'h0D0D, 16'h07AA, 16'h0B0B, 16'h0A0A}, 4'b0100, 4'b0000, 16'h07AA, 16'd1};
      vecs[8] = '{4'b0011, 1'b0, {16'h0D0D, 16'h0C0C, 16'h04CC, 16'h0A0A}, 4'b0010, 4'b0000, 16'h04CC, 16'd2};
      vecs[9] = '{4'b0011, 1'b0, {16'h0D0D, 16'h0C0C, 16'h0B0B, 16'h02EE}, 4'b0001, 4'b0100, 16'h02EE, 16'd2};

      // Reset state, with requests present while reset is held.
      @(negedge clk);
      pndng = 4'b1111;
      @(negedge clk);
      check("rst_pop", 64'(pop), 64'd0);
      check("rst_push", 64'(push), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_drop", 64'(drop_cnt), 64'd0);
      check("rst_dpush", 64'(D_push), 64'd0);
      pndng = '0;
      reset = 1'b0;

      for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

      // Fairness: held requests, 8 grants in RR then 8 in fixed priority.
      do_reset();
      D_pop = {16'h0000, 16'h0300, 16'h0200, 16'h0100};
      pndng = 4'b1111;
      pops  = 0;
      for (int c = 0; c < 200 && pops < 16; c++) begin
         @(negedge clk);
         if (pop != '0) begin
            check($sformatf("fair_grant%0d", pops), 64'(pop),
                  64'(4'b0001 << ((pops < 8) ? (pops % 4) : 0)));
            pops++;
            if (pops == 8) mode = 1'b1;
         end
      end
      check("fair_count", 64'(pops), 64'd16);
      @(negedge clk);
      pndng = '0;
      mode  = 1'b0;
      wait_idle("fair");

      // Backpressure on a unicast.
      D_pop = {16'h0D0D, 16'h0C0C, 16'h0B0B, 16'h0200};
      full  = 4'b0100;
      pndng = 4'b0001;
      wait_pop("bp_uni_pop", p);
      @(negedge clk);
      pndng = '0;
      seen  = '0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         seen |= push;
      end
      check("bp_uni_hold", 64'(seen), 64'd0);
      check("bp_uni_busy", 64'(busy), 64'd1);
      full = '0;
      @(negedge clk);
      check("bp_uni_push", 64'(push), 64'b0100);
      check("bp_uni_data", 64'(D_push), {4{16'h0200}});
      @(negedge clk);
      check("bp_uni_once", 64'(push), 64'd0);

      // Backpressure on a broadcast: no lane moves until all targets free.
      D_pop = {16'h0D0D, 16'h0C0C, 16'h0B0B, 16'hFF00};
      full  = 4'b0010;
      pndng = 4'b0001;
      wait_pop("bp_bc_pop", p);
      @(negedge clk);
      pndng = '0;
      seen  = '0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         seen |= push;
         if (c == 4) full = 4'b0100;
      end
      check("bp_bc_hold", 64'(seen), 64'd0);
      full = 4'b0001;
      @(negedge clk);
      check("bp_bc_push", 64'(push), 64'b1110);
      check("bp_bc_data", 64'(D_push), {4{16'hFF00}});
      @(negedge clk);
      full = '0;
      check("bp_bc_once", 64'(push), 64'd0);

      // Reset while blocked in CHECK.
      do_reset();
      D_pop = {16'h0D0D, 16'h0C0C, 16'h0000, 16'h0A0A};
      pndng = 4'b0010;
      wait_pop("mf_a", p);
      @(negedge clk);
      pndng = '0;
      wait_idle("mf_a");
      D_pop[1] = 16'h0500;
      pndng    = 4'b0010;
      wait_pop("mf_b", p);
      @(negedge clk);
      pndng = '0;
      wait_idle("mf_b");
      check("mf_drop_pre", 64'(drop_cnt), 64'd1);
      D_pop[2] = 16'h0300;
      full     = 4'b1000;
      pndng    = 4'b0100;
      wait_pop("mf_c", p);
      check("mf_c_grant", 64'(p), 64'b0100);
      @(negedge clk);
      pndng = '0;
      repeat (3) @(negedge clk);
      check("mf_blocked", 64'(busy), 64'd1);
      reset = 1'b1;
      pndng = 4'b1001;
      D_pop = {16'h0200, 16'h0C0C, 16'h0B0B, 16'h0100};
      full  = '0;
      @(negedge clk);
      check("mf_rst_outs", 64'({pop, push, busy}), 64'd0);
      check("mf_rst_drop", 64'(drop_cnt), 64'd0);
      check("mf_rst_dpush", 64'(D_push), 64'd0);
      reset = 1'b0;
      wait_pop("mf_after", p);
      check("mf_after_grant", 64'(p), 64'b0001);
      @(negedge clk);
      pndng = '0;
      wait_push("mf_after", p);
      check("mf_after_push", 64'(p), 64'b0010);
      check("mf_after_data", 64'(D_push), {4{16'h0100}});
      wait_idle("mf_after");

      // Drop counter saturation on the second instance.
      D_pop2 = {4{16'h1000}};
      pndng2 = 4'b0001;
      pops   = 0;
      seen   = '0;
      for (int c = 0; c < 400 && pops < 10; c++) begin
         @(negedge clk);
         seen |= push2;
         if (pop2 != '0) pops++;
      end
      @(negedge clk);
      pndng2 = '0;
      for (int c = 0; c < 20 && busy2; c++) @(negedge clk);
      check("sat_pops_a", 64'(pops), 64'd10);
      check("sat_cnt_a", 64'(drop2), 64'((pops < 20) ? pops : 20));
      pndng2 = 4'b0001;
      for (int c = 0; c < 800 && pops < 30; c++) begin
         @(negedge clk);
         seen |= push2;
         if (pop2 != '0) pops++;
      end
      @(negedge clk);
      pndng2 = '0;
      for (int c = 0; c < 20 && busy2; c++) @(negedge clk);
      check("sat_pops_b", 64'(pops), 64'd30);
      check("sat_cnt_b", 64'(drop2), 64'((pops < 20) ? pops : 20));
      check("sat_no_push", 64'(seen), 64'd0);
      check("sat_dpush", 64'(D_push2), {4{16'h1000}});

      // Randomized traffic against the transaction model.
      do_reset();
      mode    = 1'b0;
      rr_m    = 0;
      drop_m  = 0;
      consume = -1;
      exp_q.delete();
      for (int c = 0; c < 3000; c++) step(1'b1);
      for (int c = 0; c < 400; c++) begin
         if (exp_q.size() == 0 && pndng == '0 && !busy && consume < 0) break;
         step(1'b0);
      end
      check("rnd_drain_left", 64'(exp_q.size()), 64'd0);
      check("rnd_drain_busy", 64'(busy), 64'd0);
      check("rnd_drain_drop", 64'(drop_cnt), 64'(drop_m));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/bus_arb_router.md
Name: bus_arb_router

Overview:
- Parametrised successor to the shared-bus generator/arbiter used by the bus testbench.
- Collects packets from N driver queues through a pndng/pop handshake.
- Arbitrates between drivers in round-robin or fixed-priority mode, decodes the destination ID in each packet header, and pushes the packet to one or all other drivers.
- New over the previous generation: per-destination backpressure (full), runtime arbitration mode, configurable ID width, and a dropped-packet counter for invalid destinations.

Parameters:
drvrs, 4, number of driver ports (2..32)
pckg_sz, 16, packet width in bits; must be greater than id_w
id_w, 8, width of destination ID field in packet MSBs [pckg_sz-1 -: id_w]
broadcast, {id_w{1'b1}}, ID value meaning "deliver to all drivers except the source"

Ports:
clk  in  1  single clock, all logic on posedge
reset  in  1  synchronous, active-high
pndng  in  drvrs  bit i high: driver i's queue head is valid
D_pop  in  drvrs x pckg_sz  head packet of driver i; valid while pndng[i]
pop  out  drvrs  one-cycle pulse consuming driver i's head
full  in  drvrs  bit i high: driver i cannot accept a push this cycle
mode  in  1  0 = round-robin, 1 = fixed priority (lowest index wins)
push  out  drvrs  one-cycle push strobe per destination
D_push  out  drvrs x pckg_sz  packet data; every lane carries the latched packet, qualified by push
drop_cnt  out  16  saturating count of packets dropped for an invalid ID
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (synchronous, checked at posedge): state=IDLE, pop=0, push=0, D_push=0, drop_cnt=0, rr_ptr=0, latched packet, source and mask cleared, busy=0. Reset asserted mid-transaction aborts it. No push is issued for an already-popped packet.
- FSM states: IDLE, POP, CHECK, PUSH.
- IDLE:
  - If pndng!=0, select grant g and go to POP.
  - mode is sampled only here.
  - Round-robin: first set bit of pndng searching from rr_ptr upward with wrap; then rr_ptr <= (g+1) mod drvrs.
  - Fixed priority: lowest set index; rr_ptr unchanged.
- POP:
  - pop[g]=1 for exactly this cycle; all other pop bits 0.
  - At the closing edge: latch pkt<=D_pop[g], src<=g, and the destination mask decoded from pkt's ID field. Go to CHECK.
- Mask decode:
  - ID==broadcast: mask = all ones with bit src cleared.
  - ID<drvrs: mask = one-hot(ID). Loopback (ID==src) is legal.
  - Otherwise: mask=0.
  - broadcast takes precedence even if numerically <drvrs.
  - With drvrs==1, a broadcast mask is 0 and is treated as a drop.
- CHECK:
  - mask==0: drop_cnt += 1 (saturate at 16'hFFFF), go to IDLE.
  - Else if (mask & full)==0: go to PUSH.
  - Else stay; wait indefinitely with no timeout.
  - A broadcast waits until all targets are simultaneously not full; there are no partial deliveries.
- PUSH:
  - push=mask (registered) for exactly one cycle; D_push lanes = pkt.
  - Then IDLE.
  - D_push holds pkt after PUSH until the next latch.
- Latency and throughput:
  - IDLE seeing pndng to pop pulse: 1 cycle.
  - pop pulse to push pulse: 2 cycles when not blocked.
  - Back-to-back throughput: one packet per 4 cycles.
- pndng dropping during POP is a protocol violation by the driver; the block still latches D_pop.
- pop and push are never both asserted in the same cycle.

Decomposition:
- Package bus_arb_pkg:
  - state enum (IDLE, POP, CHECK, PUSH).
  - MODE_RR / MODE_FP constants.
  - Function dest_mask(id, src, drvrs, broadcast) returning a drvrs-bit mask.
- Sub-module bus_arb_core (drvrs):
  - Combinational request-to-grant index for both modes from pndng, rr_ptr and mode.
  - Instantiated once; the FSM owns rr_ptr.

Test Plan:
1. Unicast, RR, drvrs=4: pndng=4'b0010, D_pop[1]=16'h02AB, full=0 -> pop[1] pulses 1 cycle after pndng, push=4'b0100 with D_push=16'h02AB 2 cycles later; drop_cnt=0.
2. Broadcast from src 3: D_pop[3]=16'hFF55 -> push=4'b0111 for one cycle, all lanes 16'hFF55, push[3]=0.
3. Arbitration fairness:
   - pndng=4'b1111 held for 8 packets, mode=0 -> grants 0,1,2,3,0,1,2,3.
   - Same with mode=1 -> grants 0 every time.
4. Backpressure: unicast to dest 2 with full[2]=1 for 10 cycles -> FSM holds in CHECK, push=0 throughout; push[2] pulses the cycle after full[2] falls. Repeat as a broadcast with one target full: no lane pushes until all targets are free.
5. Invalid ID 16'h07xx with drvrs=4 -> no push, drop_cnt increments to 1. Preload drop_cnt near 16'hFFFF with 65536 drops -> it stays at 16'hFFFF.
6. Reset mid-flight: assert reset during CHECK while blocked -> next cycle all outputs 0, busy=0. After release, the next grant in RR starts from index 0 and the aborted packet is never pushed.
